// File: rtl/branch_pkg.sv
// Shared branch-unit definitions.
//   BTB_ADDR_W    : default PC / target width
//   BTB_UPD_DEPTH : default depth of the pending BTB update queue
//   btb_update_t  : one BTB write (branch PC + resolved target)
package branch_pkg;

  localparam int BTB_ADDR_W    = 32;
  localparam int BTB_UPD_DEPTH = 4;

  typedef struct packed {
    logic [BTB_ADDR_W-1:0] pc;
    logic [BTB_ADDR_W-1:0] target;
  } btb_update_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending BTB update queue with a parallel PC lookup.
//   clk, rst        : clock, asynchronous active-high reset (control state only)
//   flush           : empty the queue at the next edge
//   push/push_pc/push_target : write a new entry at the tail
//   pop             : retire the head entry at the next edge
//   cmp_pc          : PC looked up against every occupied entry
//   match           : per-entry hit vector (head excluded while it is popping)
//   ovr_en/ovr_target : per-entry target overwrite (coalescing)
//   head_pc/head_target : entry at the read pointer
//   count/empty     : occupancy
module btb_upd_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [ADDR_WIDTH-1:0] push_target,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] cmp_pc,
  output logic [DEPTH-1:0]      match,
  input  logic [DEPTH-1:0]      ovr_en,
  input  logic [ADDR_WIDTH-1:0] ovr_target,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [ADDR_WIDTH-1:0] head_target,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_q [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [DEPTH-1:0]      occ;
  logic [PW-1:0]         off;

  // Storage: data only, never reset. A coalescing overwrite can never target
  // the slot being pushed because a push only happens on a lookup miss.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PW'(i))) begin
        pc_q[i]  <= push_pc;
        tgt_q[i] <= push_target;
      end else if (ovr_en[i]) begin
        tgt_q[i] <= ovr_target;
      end
    end
  end

  // Pointers wrap naturally; count separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    occ   = '0;
    match = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      occ[i]   = (CW'(off) < count);
      match[i] = occ[i] && (pc_q[i] == cmp_pc) && !(pop && (rd_ptr == PW'(i)));
    end
  end

  assign empty       = (count == '0);
  assign head_pc     = pc_q[rd_ptr];
  assign head_target = tgt_q[rd_ptr];

`ifndef SYNTHESIS
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = i + 1; j < DEPTH; j++) begin
        if (occ[i] && occ[j] && (pc_q[i] == pc_q[j])) dup = 1'b1;
      end
    end
  end

  a_no_dup_pc: assert property (@(posedge clk) disable iff (rst) !dup)
    else $error("btb_upd_fifo: duplicate pc queued");
`endif

endmodule

// File: rtl/btb_update_sched.sv
// Branch-resolution update scheduler for the single-write-port BTB.
//   clk, rst                       : clock, asynchronous active-high reset
//   req0_* (valid/pc/target/ready) : conditional-branch resolve requester
//   req1_* (valid/pc/target/ready) : JAL/JALR resolve requester
//   drain_en                       : BTB write port free this cycle
//   flush                          : discard all pending updates
//   btb_valid/btb_update_pc/btb_target_pc : BTB write
//   pending_count                  : queued updates
// Two requesters are round-robin arbitrated into a coalescing queue; a PC
// already queued only has its target refreshed in place.
module btb_update_sched
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = BTB_ADDR_W,
  parameter int DEPTH      = BTB_UPD_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  input  logic [ADDR_WIDTH-1:0]        req0_pc,
  input  logic [ADDR_WIDTH-1:0]        req0_target,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [ADDR_WIDTH-1:0]        req1_pc,
  input  logic [ADDR_WIDTH-1:0]        req1_target,
  output logic                         req1_ready,
  input  logic                         drain_en,
  input  logic                         flush,
  output logic                         btb_valid,
  output logic [ADDR_WIDTH-1:0]        btb_update_pc,
  output logic [ADDR_WIDTH-1:0]        btb_target_pc,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic                  rr_q;       // 0: req0 wins a tie, 1: req1 wins
  logic                  sel;
  logic                  cand_valid;
  logic [ADDR_WIDTH-1:0] cand_pc;
  logic [ADDR_WIDTH-1:0] cand_target;
  logic [DEPTH-1:0]      match;
  logic                  hit;
  logic                  acc;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [ADDR_WIDTH-1:0] head_target;
  logic [CW-1:0]         count;
  logic                  empty;

  always_comb begin
    sel = rr_q;
    if (req0_valid && !req1_valid) sel = 1'b0;
    else if (!req0_valid && req1_valid) sel = 1'b1;
  end

  assign cand_valid  = req0_valid | req1_valid;
  assign cand_pc     = sel ? req1_pc : req0_pc;
  assign cand_target = sel ? req1_target : req0_target;

  assign pop = !empty && drain_en && !flush;
  assign hit = |match;

  // A hit never needs space; a miss needs a free slot or a simultaneous pop.
  // rst gates ready so it drops asynchronously with the rest of the outputs.
  assign acc  = !rst && cand_valid && !flush &&
                (hit || (count < CW'(DEPTH)) || pop);
  assign push = acc && !hit;

  assign req0_ready = acc && !sel;
  assign req1_ready = acc && sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (acc && req0_valid && req1_valid) begin
      rr_q <= !sel;
    end
  end

  btb_upd_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (push),
    .push_pc     (cand_pc),
    .push_target (cand_target),
    .pop         (pop),
    .cmp_pc      (cand_pc),
    .match       (match),
    .ovr_en      (match & {DEPTH{acc}}),
    .ovr_target  (cand_target),
    .head_pc     (head_pc),
    .head_target (head_target),
    .count       (count),
    .empty       (empty)
  );

  assign btb_valid     = pop;
  assign btb_update_pc = pop ? head_pc : '0;
  assign btb_target_pc = pop ? head_target : '0;
  assign pending_count = count;

endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;
  import branch_pkg::*;

  localparam int AW = 32;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_pc, req0_target, req1_pc, req1_target;
  logic          drain_en, flush, btb_valid;
  logic [AW-1:0] btb_update_pc, btb_target_pc;
  logic [2:0]    pending_count;

  int checks   = 0;
  int failures = 0;

  btb_update_t exp_q[$];

  typedef struct {
    logic          v0;
    logic [AW-1:0] pc0;
    logic [AW-1:0] tg0;
    logic          v1;
    logic [AW-1:0] pc1;
    logic [AW-1:0] tg1;
    logic          drain;
    logic          coal;
    logic          exp_r0;
    logic          exp_r1;
    logic          exp_bv;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[14];

  btb_update_sched #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_pc       (req0_pc),
    .req0_target   (req0_target),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_pc       (req1_pc),
    .req1_target   (req1_target),
    .req1_ready    (req1_ready),
    .drain_en      (drain_en),
    .flush         (flush),
    .btb_valid     (btb_valid),
    .btb_update_pc (btb_update_pc),
    .btb_target_pc (btb_target_pc),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] p0, input logic [AW-1:0] t0,
                       input logic v1, input logic [AW-1:0] p1, input logic [AW-1:0] t1,
                       input logic dr, input logic fl);
    req0_valid = v0; req0_pc = p0; req0_target = t0;
    req1_valid = v1; req1_pc = p1; req1_target = t1;
    drain_en = dr; flush = fl;
  endtask

  // Wait to the falling edge and score any BTB write against the queue.
  task automatic sample();
    btb_update_t e;
    @(negedge clk);
    if (btb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL btb_unexpected actual=%0h/%0h required=none", btb_update_pc, btb_target_pc);
      end else begin
        e = exp_q.pop_front();
        chk("btb_pc", btb_update_pc, e.pc);
        chk("btb_tgt", btb_target_pc, e.target);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] p0, input logic [AW-1:0] t0,
                              input logic v1, input logic [AW-1:0] p1, input logic [AW-1:0] t1,
                              input logic dr, input logic cl, input logic r0, input logic r1,
                              input logic bv, input int cnt);
    vec_t v;
    v.v0 = v0; v.pc0 = p0; v.tg0 = t0; v.v1 = v1; v.pc1 = p1; v.tg1 = t1;
    v.drain = dr; v.coal = cl; v.exp_r0 = r0; v.exp_r1 = r1; v.exp_bv = bv; v.exp_cnt = cnt;
    return v;
  endfunction

  initial begin
    btb_update_t e;

    // round robin fill, full stall, full+pop, coalesce on full, head-popping
    // same-pc miss, then drain in order
    vecs[0]  = mk(1, 32'h1000, 32'h11000, 1, 32'h2000, 32'h12000, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 32'h1004, 32'h11004, 1, 32'h2000, 32'h12000, 0, 0, 0, 1, 0, 1);
    vecs[2]  = mk(1, 32'h1004, 32'h11004, 1, 32'h2004, 32'h12004, 0, 0, 1, 0, 0, 2);
    vecs[3]  = mk(1, 32'h1008, 32'h11008, 1, 32'h2004, 32'h12004, 0, 0, 0, 1, 0, 3);
    vecs[4]  = mk(1, 32'h1008, 32'h11008, 1, 32'h2008, 32'h12008, 0, 0, 0, 0, 0, 4);
    vecs[5]  = mk(1, 32'h0500, 32'h00600, 0, 32'h0,    32'h0,     1, 0, 1, 0, 1, 4);
    vecs[6]  = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     0, 0, 0, 0, 0, 4);
    vecs[7]  = mk(0, 32'h0,    32'h0,     1, 32'h2004, 32'h07777, 0, 1, 0, 1, 0, 4);
    vecs[8]  = mk(1, 32'h2000, 32'h08888, 0, 32'h0,    32'h0,     1, 0, 1, 0, 1, 4);
    vecs[9]  = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     1, 0, 0, 0, 1, 4);
    vecs[10] = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     1, 0, 0, 0, 1, 3);
    vecs[11] = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     1, 0, 0, 0, 1, 2);
    vecs[12] = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     1, 0, 0, 0, 1, 1);
    vecs[13] = mk(0, 32'h0,    32'h0,     0, 32'h0,    32'h0,     1, 0, 0, 0, 0, 0);

    // reset state, with a request and drain offered
    rst = 1'b1;
    drive(1, 32'h123, 32'h456, 1, 32'h789, 32'hABC, 1, 0);
    #3;
    chk("rst_btb_valid", btb_valid, 0);
    chk("rst_btb_pc", btb_update_pc, 0);
    chk("rst_btb_tgt", btb_target_pc, 0);
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);
    chk("rst_count", pending_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single update
    drive(1, 32'h100, 32'h200, 0, 0, 0, 1, 0);
    sample();
    chk("t1_r0", req0_ready, 1);
    chk("t1_r1", req1_ready, 0);
    chk("t1_bv_c0", btb_valid, 0);
    exp_q.push_back('{pc: 32'h100, target: 32'h200});
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t1_bv_c1", btb_valid, 1);
    chk("t1_cnt_c1", pending_count, 1);
    adv();
    sample();
    chk("t1_cnt_c2", pending_count, 0);
    chk("t1_bv_c2", btb_valid, 0);
    adv();

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v0, vecs[i].pc0, vecs[i].tg0, vecs[i].v1, vecs[i].pc1, vecs[i].tg1,
            vecs[i].drain, 0);
      sample();
      chk($sformatf("v%0d_r0", i), req0_ready, vecs[i].exp_r0);
      chk($sformatf("v%0d_r1", i), req1_ready, vecs[i].exp_r1);
      chk($sformatf("v%0d_bv", i), btb_valid, vecs[i].exp_bv);
      chk($sformatf("v%0d_cnt", i), pending_count, 64'(vecs[i].exp_cnt));
      if (vecs[i].coal) begin
        for (int k = 0; k < exp_q.size(); k++) begin
          e = exp_q[k];
          if (vecs[i].exp_r1 && e.pc == vecs[i].pc1) begin e.target = vecs[i].tg1; exp_q[k] = e; end
          if (vecs[i].exp_r0 && e.pc == vecs[i].pc0) begin e.target = vecs[i].tg0; exp_q[k] = e; end
        end
      end else begin
        if (vecs[i].exp_r0) exp_q.push_back('{pc: vecs[i].pc0, target: vecs[i].tg0});
        if (vecs[i].exp_r1) exp_q.push_back('{pc: vecs[i].pc1, target: vecs[i].tg1});
      end
      adv();
    end

    // coalesce: second update to the same pc refreshes the target only
    drive(1, 32'h40, 32'h80, 0, 0, 0, 0, 0);
    sample();
    chk("t3_r0_a", req0_ready, 1);
    adv();
    drive(1, 32'h40, 32'hC0, 0, 0, 0, 0, 0);
    sample();
    chk("t3_r0_b", req0_ready, 1);
    chk("t3_cnt_b", pending_count, 1);
    exp_q.push_back('{pc: 32'h40, target: 32'hC0});
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("t3_cnt_hold", pending_count, 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t3_bv", btb_valid, 1);
    adv();
    sample();
    chk("t3_bv_after", btb_valid, 0);
    chk("t3_cnt_after", pending_count, 0);
    adv();

    // flush with three queued; round-robin pointer set to req1 beforehand
    drive(1, 32'h300, 32'h3300, 1, 32'h304, 32'h3304, 0, 0);
    sample();
    chk("t5_fill0_r0", req0_ready, 1);
    chk("t5_fill0_r1", req1_ready, 0);
    adv();
    drive(0, 0, 0, 1, 32'h304, 32'h3304, 0, 0);
    sample();
    chk("t5_fill1_r1", req1_ready, 1);
    adv();
    drive(1, 32'h308, 32'h3308, 0, 0, 0, 0, 0);
    sample();
    chk("t5_fill2_r0", req0_ready, 1);
    adv();
    drive(1, 32'h900, 32'h9900, 1, 32'h904, 32'h9904, 1, 1);
    sample();
    chk("t5_flush_r0", req0_ready, 0);
    chk("t5_flush_r1", req1_ready, 0);
    chk("t5_flush_bv", btb_valid, 0);
    chk("t5_flush_cnt", pending_count, 3);
    adv();
    drive(1, 32'hA00, 32'hA100, 1, 32'hA04, 32'hA104, 0, 0);
    sample();
    chk("t5_post_cnt", pending_count, 0);
    chk("t5_post_r0", req0_ready, 0);
    chk("t5_post_r1", req1_ready, 1);
    exp_q.push_back('{pc: 32'hA04, target: 32'hA104});
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t5_drain_bv", btb_valid, 1);
    adv();
    sample();
    chk("t5_idle_bv", btb_valid, 0);
    chk("t5_idle_cnt", pending_count, 0);
    adv();

    // asynchronous reset while a write is on the port
    drive(1, 32'hB00, 32'hB100, 1, 32'hB04, 32'hB104, 0, 0);
    sample();
    chk("t6_fill0_r0", req0_ready, 1);
    exp_q.push_back('{pc: 32'hB00, target: 32'hB100});
    adv();
    drive(0, 0, 0, 1, 32'hB04, 32'hB104, 0, 0);
    sample();
    chk("t6_fill1_r1", req1_ready, 1);
    exp_q.push_back('{pc: 32'hB04, target: 32'hB104});
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t6_bv_pre", btb_valid, 1);
    #2;
    rst = 1'b1;
    drive(1, 32'hE00, 32'hE100, 1, 32'hE04, 32'hE104, 1, 0);
    #1;
    chk("t6_rst_bv", btb_valid, 0);
    chk("t6_rst_pc", btb_update_pc, 0);
    chk("t6_rst_tgt", btb_target_pc, 0);
    chk("t6_rst_r0", req0_ready, 0);
    chk("t6_rst_r1", req1_ready, 0);
    chk("t6_rst_cnt", pending_count, 0);
    exp_q.delete();
    adv();
    rst = 1'b0;
    drive(1, 32'hE00, 32'hE100, 1, 32'hE04, 32'hE104, 0, 0);
    sample();
    chk("t6_rr_r0", req0_ready, 1);
    chk("t6_rr_r1", req1_ready, 0);
    chk("t6_rr_cnt", pending_count, 0);
    exp_q.push_back('{pc: 32'hE00, target: 32'hE100});
    adv();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t6_out_bv", btb_valid, 1);
    adv();
    sample();
    chk("t6_end_bv", btb_valid, 0);
    chk("t6_end_cnt", pending_count, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_update_sched.md
Name: btb_update_sched

Overview:
- Schedules branch-resolution updates into the single-write-port branch target buffer.
- Two requesters (req0 = EX-stage conditional branch resolve, req1 = EX-stage JAL/JALR resolve) share the port via a round-robin arbiter.
- Accepted updates go into a small coalescing FIFO, drained at most one per cycle into the BTB update port when the pipeline allows (drain_en).
- Sits between the EX/MEM boundary and the BTB; also clears pending updates on pipeline flush.

Parameters:
ADDR_WIDTH, 32, width of PC and target addresses
DEPTH, 4, pending-update FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset
req0_valid  in  1  requester 0 has an update
req0_pc  in  ADDR_WIDTH  branch PC, requester 0
req0_target  in  ADDR_WIDTH  resolved target, requester 0
req0_ready  out  1  requester 0 update accepted this cycle
req1_valid  in  1  requester 1 has an update
req1_pc  in  ADDR_WIDTH  branch PC, requester 1
req1_target  in  ADDR_WIDTH  resolved target, requester 1
req1_ready  out  1  requester 1 update accepted this cycle
drain_en  in  1  BTB write port available this cycle
flush  in  1  discard all pending updates
btb_valid  out  1  BTB write strobe
btb_update_pc  out  ADDR_WIDTH  PC to write
btb_target_pc  out  ADDR_WIDTH  target to write
pending_count  out  $clog2(DEPTH+1)  entries currently queued

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
- While rst is asserted:
  - FIFO empty; rd/wr pointers 0; pending_count 0.
  - RR pointer = requester 0.
  - btb_valid 0; btb_update_pc / btb_target_pc 0.
  - req0_ready / req1_ready 0.
- Arbitration:
  - Only one update is accepted per cycle.
  - If exactly one reqN_valid is high, that requester is the candidate.
  - If both are high, the requester named by the RR pointer is the candidate.
  - The RR pointer flips to the other requester only on a completed handshake (valid & ready) while both were valid. It is unchanged otherwise.
  - Ready is combinational from valid, FIFO state and flush. The loser's ready is 0.
- Drain (pop):
  - pop = !empty & drain_en & !flush.
  - btb_valid = pop.
  - btb_update_pc / btb_target_pc = head entry when pop is high, else 0.
  - Head advances at the clock edge.
- Coalescing:
  - The candidate pc is compared against every occupied entry, excluding the head when pop=1.
  - On a hit, the candidate is accepted (ready=1). The matching entry's target is overwritten and count is unchanged.
  - At most one entry can match, as an invariant. An assertion checks for duplicate PCs.
- Enqueue:
  - Applies on a miss.
  - Candidate ready = !flush & (count<DEPTH | pop).
  - Entry written at the tail; count+1, or unchanged if pop in the same cycle.
- Latency:
  - An update accepted at edge t is presented on btb_* no earlier than the cycle after t.
  - There is no input-to-output bypass.
  - FIFO order is preserved; coalesced entries keep their original position.
- Full: count==DEPTH, no pop, no coalesce hit -> both readies 0; state unchanged.
- Empty: btb_valid 0 regardless of drain_en.
- Simultaneous full + pop + miss: push and pop both occur; count stays DEPTH.
- Flush:
  - Synchronous: next cycle FIFO empty, count 0.
  - During the flush cycle, ready=0 and btb_valid=0.
  - RR pointer unchanged.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; a separate count register disambiguates full from empty.
- Reset mid-operation: all queued updates are lost immediately; outputs go to reset values asynchronously.

Decomposition:
- Shared package branch_pkg:
  - typedef btb_update_t packed struct {pc, target}, sized by ADDR_WIDTH.
  - localparam BTB_UPD_DEPTH = 4.
- One sub-module, btb_upd_fifo:
  - Storage, pointers and count.
  - Parallel pc-match vector output and per-entry target-overwrite input.
- Arbiter and coalescing control stay in btb_update_sched.

Test Plan:
1. Single update:
   - Stimulus: req0 pc=0x100 target=0x200 at cycle 0; drain_en=1.
   - Response: req0_ready=1 at cycle 0; btb_valid=1 with 0x100/0x200 at cycle 1; count back to 0 at cycle 2.
2. Round-robin:
   - Stimulus: both requesters valid for 4 cycles with distinct PCs; drain_en=0.
   - Response: grants go 0,1,0,1; count=4; fifth cycle has both readies 0.
3. Coalesce:
   - Stimulus: enqueue pc=0x40 target=0x80, then pc=0x40 target=0xC0; drain_en=0.
   - Response: count stays 1; after drain_en=1, a single write 0x40/0xC0 is emitted.
4. Full with pop:
   - Stimulus: fill 4 entries; then drain_en=1 with a new pc=0x500.
   - Response: accepted; head written out; count stays 4; order preserved.
5. Flush:
   - Stimulus: 3 entries queued; flush=1 with drain_en=1 and req0 valid.
   - Response: btb_valid=0 and req0_ready=0 that cycle; count=0 next cycle; no writes follow.
6. Async reset mid-drain:
   - Stimulus: assert rst between clock edges while btb_valid=1.
   - Response: btb_valid, btb_* and readies drop to 0 immediately; count=0; RR pointer = req0 after release.
